// File: rtl/dot_feeder.sv
// dot_feeder: initiator for a 2-lane multiply-add pipeline (C = A1*B1 + A2*B2).
// Packs streamed (a,b) pairs into lane-1/lane-2 operands and issues them.
// Tracks in-flight issues with a tag shift register and accumulates the returned C values.
// Optional feature macro: ACC_OVF_EN adds a sticky accumulator-carry output 'ovf'.
module dot_feeder #(
  parameter int LEN_W    = 8,
  parameter int PIPE_LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  output logic [31:0]      pipe_A1,
  output logic [31:0]      pipe_B1,
  output logic [31:0]      pipe_A2,
  output logic [31:0]      pipe_B2,
  input  logic [31:0]      pipe_C,
  output logic             busy,
  output logic             done,
  output logic [31:0]      result
`ifdef ACC_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int TAG_W = PIPE_LAT + 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic             odd_q, odd_d;
  logic [31:0]      hold_a_q, hold_a_d, hold_b_q, hold_b_d;
  logic [31:0]      a1_q, a1_d, b1_q, b1_d, a2_q, a2_d, b2_q, b2_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [31:0]      acc_q, acc_d, result_q, result_d;
  logic             handshake, last_pair, retire;

  // Accumulator adder; the wide form keeps the carry for the overflow flag.
`ifdef ACC_OVF_EN
  logic             ovf_q, ovf_d;
  logic [32:0]      acc_sum;
  assign acc_sum = {1'b0, acc_q} + {1'b0, pipe_C};
`else
  logic [31:0]      acc_sum;
  assign acc_sum = acc_q + pipe_C;
`endif

  assign in_ready  = (state_q == S_LOAD);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign result    = result_q;
  assign pipe_A1   = a1_q;
  assign pipe_B1   = b1_q;
  assign pipe_A2   = a2_q;
  assign pipe_B2   = b2_q;
  assign handshake = in_valid & in_ready;
  assign last_pair = (remaining_q == LEN_W'(1));
  // A tag reaching the MSB means pipe_C now carries that issue's result.
  assign retire    = tag_q[TAG_W-1];
`ifdef ACC_OVF_EN
  assign ovf       = ovf_q;
`endif

  // Next-state logic: FSM, lane packing, issue, tag shift and accumulation.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    odd_d       = odd_q;
    hold_a_d    = hold_a_q;
    hold_b_d    = hold_b_q;
    a1_d        = a1_q;
    b1_d        = b1_q;
    a2_d        = a2_q;
    b2_d        = b2_q;
    tag_d       = {tag_q[TAG_W-2:0], 1'b0};
    acc_d       = acc_q;
    result_d    = result_q;
`ifdef ACC_OVF_EN
    ovf_d       = ovf_q;
`endif

    // Retire applies independently of any issue in the same cycle.
    if (retire) begin
      acc_d = acc_sum[31:0];
`ifdef ACC_OVF_EN
      ovf_d = ovf_q | acc_sum[32];
`endif
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          remaining_d = len;
          odd_d       = 1'b0;
          acc_d       = '0;
`ifdef ACC_OVF_EN
          ovf_d       = 1'b0;
`endif
          if (len == '0) begin
            result_d = '0;
            state_d  = S_DONE;
          end else begin
            state_d  = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (handshake) begin
          remaining_d = remaining_q - LEN_W'(1);
          odd_d       = ~odd_q;
          if (odd_q) begin
            // Second pair of a couple: issue both lanes together.
            a1_d     = hold_a_q;
            b1_d     = hold_b_q;
            a2_d     = in_a;
            b2_d     = in_b;
            tag_d[0] = 1'b1;
          end else if (last_pair) begin
            // Odd-length vector tail: lane 2 is zero padded.
            a1_d     = in_a;
            b1_d     = in_b;
            a2_d     = '0;
            b2_d     = '0;
            tag_d[0] = 1'b1;
          end else begin
            hold_a_d = in_a;
            hold_b_d = in_b;
          end
          if (last_pair) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // Empty tag register means the last retire has already landed in acc.
        if (tag_q == '0) begin
          result_d = acc_q;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset; reset drops all in-flight tags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      odd_q       <= 1'b0;
      hold_a_q    <= '0;
      hold_b_q    <= '0;
      a1_q        <= '0;
      b1_q        <= '0;
      a2_q        <= '0;
      b2_q        <= '0;
      tag_q       <= '0;
      acc_q       <= '0;
      result_q    <= '0;
`ifdef ACC_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      odd_q       <= odd_d;
      hold_a_q    <= hold_a_d;
      hold_b_q    <= hold_b_d;
      a1_q        <= a1_d;
      b1_q        <= b1_d;
      a2_q        <= a2_d;
      b2_q        <= b2_d;
      tag_q       <= tag_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
`ifdef ACC_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

endmodule
